seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 23 ++
 rtl/seq_multiplier_adder.sv | 37 +++
 rtl/seq_multiplier.sv | 131 +++++++++++++
 tb/tb_seq_multiplier.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_pkg
//   Shared constants and the FSM state encoding for the sequential
//   shift-and-add multiplier.
//
//   WIDTH : operand width (8)
//   ITER  : number of shift-add steps per multiplication (8)
//   CNT_W : width of the step counter (4)
//   state_t : IDLE=0, RUN=1, DONE=2
// -----------------------------------------------------------------------------
package seq_multiplier_pkg;

    localparam int WIDTH = 8;
    localparam int ITER  = 8;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_adder.sv
// -----------------------------------------------------------------------------
// adder
//   Plain ripple-carry adder. The final carry is deliberately not exported;
//   callers that need it must recover it themselves.
//
//   Ports:
//     A      [AW-1:0] in  : first addend
//     B      [AW-1:0] in  : second addend
//     Result [AW-1:0] out : (A + B) modulo 2**AW
// -----------------------------------------------------------------------------
module adder
    import seq_multiplier_pkg::*;
#(
    parameter int AW = WIDTH
) (
    input  logic [AW-1:0] A,
    input  logic [AW-1:0] B,
    output logic [AW-1:0] Result
);

    // w_carry[i] is the carry into bit i; the carry out of the top bit is
    // never formed.
    logic [AW-1:0] w_carry;

    assign w_carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < AW; i++) begin : g_bit
            assign Result[i] = A[i] ^ B[i] ^ w_carry[i];
            if (i < AW - 1) begin : g_carry
                assign w_carry[i+1] = (A[i] & B[i]) | (w_carry[i] & (A[i] ^ B[i]));
            end
        end
    endgenerate

endmodule

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Unsigned 8x8 sequential shift-and-add multiplier. One step per clock,
//   eight steps per product, fixed latency.
//
//   Handshake: Start is sampled only in IDLE; when high there, A and B are
//   captured on that edge. Busy is high for the 8 RUN cycles that follow,
//   then Done pulses for exactly one cycle, in which Product first shows
//   the new result. Start is ignored in RUN and DONE (no queuing).
//
//   Ports:
//     Clock              in  : rising-edge clock
//     Reset              in  : synchronous, active-high reset
//     Start              in  : multiply request (IDLE only)
//     A, B   [WIDTH-1:0] in  : unsigned operands, captured on acceptance
//     Product[2W-1:0]    out : registered result, held between operations
//     Busy               out : high while in RUN
//     Done               out : one-cycle pulse in DONE
//     o_dbg_state [1:0]  out : current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = seq_multiplier_pkg::WIDTH
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy,
    output logic                 Done,
    output logic [1:0]           o_dbg_state
);

    import seq_multiplier_pkg::*;

    state_t              r_state;
    state_t              w_state_next;

    logic [WIDTH-1:0]    r_m;       // multiplicand
    logic [WIDTH-1:0]    r_q;       // multiplier, shifted right; fills with product low bits
    logic [WIDTH-1:0]    r_acc;     // running high half
    logic [CNT_W-1:0]    r_count;   // steps completed

    logic [WIDTH-1:0]    w_addend;
    logic [WIDTH-1:0]    w_sum;
    logic                w_carry;
    logic                w_last;

    assign w_addend = r_q[0] ? r_m : '0;

    adder #(
        .AW (WIDTH)
    ) u_adder (
        .A      (r_acc),
        .B      (w_addend),
        .Result (w_sum)
    );

    // The adder has no carry-out: an unsigned sum that wrapped is smaller
    // than either addend, so comparing against Acc recovers the carry.
    assign w_carry = (w_sum < r_acc);

    assign w_last  = (r_count == CNT_W'(ITER - 1));

    assign o_dbg_state = r_state;

    // ---------------- FSM: next state and state-decoded outputs ----------------
    always_comb begin
        w_state_next = r_state;
        Busy         = 1'b0;
        Done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                Done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------- State register and datapath ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_m     <= '0;
            r_q     <= '0;
            r_acc   <= '0;
            r_count <= '0;
            Product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_m     <= A;
                        r_q     <= B;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                RUN: begin
                    // {Acc,Q} <= {C,Sum,Q[W-1:1]}: the 2W+1-bit value shifted right one.
                    r_acc   <= {w_carry, w_sum[WIDTH-1:1]};
                    r_q     <= {w_sum[0], r_q[WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        // Same value the registers take on this edge.
                        Product <= {w_carry, w_sum, r_q[WIDTH-1:1]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Self-checking bench for seq_multiplier: directed vector table, hand-built
//   corner sequences (operand noise during RUN, mid-operation reset) and a
//   randomized back-to-back regression against A*B.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    logic        clk;
    logic        Reset;
    logic        Start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] Product;
    logic        Busy;
    logic        Done;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    logic        mon_en      = 1'b0;
    logic        rst_at_edge = 1'b0;
    logic [15:0] prev_prod   = '0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    seq_multiplier #(
        .WIDTH (8)
    ) dut (
        .Clock       (clk),
        .Reset       (Reset),
        .Start       (Start),
        .A           (A),
        .B           (B),
        .Product     (Product),
        .Busy        (Busy),
        .Done        (Done),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(posedge clk) rst_at_edge = Reset;

    always @(negedge clk) begin
        if (mon_en) begin
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 16'(Done), 16'd0);
                end else begin
                    check("sb_product", Product, exp_q.pop_front());
                end
            end else if (!rst_at_edge) begin
                check("product_hold", Product, prev_prod);
            end
        end
        prev_prod = Product;
    end

    // ---------------- driver ----------------
    // One full operation: Start in cycle N, Busy N+1..N+8, Done+Product at N+9.
    // With noise set, operands and Start are scrambled throughout RUN, and
    // Start is forced high with A=B=FF in cycle N+4.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input bit noise, input string name);
        @(negedge clk);
        check({name, "_idle_busy"}, 16'(Busy), 16'd0);
        check({name, "_idle_done"}, 16'(Done), 16'd0);
        Start = 1'b1;
        A     = a;
        B     = b;
        exp_q.push_back(exp);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            Start = 1'b0;
            if (noise) begin
                A     = 8'($urandom);
                B     = 8'($urandom);
                Start = 1'($urandom_range(0, 1));
                if (k == 4) begin
                    Start = 1'b1;
                    A     = 8'hFF;
                    B     = 8'hFF;
                end
            end
            check({name, "_run_busy"}, 16'(Busy), 16'd1);
            check({name, "_run_done"}, 16'(Done), 16'd0);
        end
        @(negedge clk);
        Start = 1'b0;
        check({name, "_fin_busy"}, 16'(Busy), 16'd0);
        check({name, "_fin_done"}, 16'(Done), 16'd1);
        check({name, "_product"}, Product, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vecs[0] = '{a: 8'd13,  b: 8'd11,  exp: 16'h008F};
        vecs[1] = '{a: 8'hFF,  b: 8'hFF,  exp: 16'hFE01};
        vecs[2] = '{a: 8'h00,  b: 8'h5A,  exp: 16'h0000};
        vecs[3] = '{a: 8'h80,  b: 8'h02,  exp: 16'h0100};
        vecs[4] = '{a: 8'h01,  b: 8'h01,  exp: 16'h0001};
        vecs[5] = '{a: 8'hFF,  b: 8'h01,  exp: 16'h00FF};

        // Reset with Start held high: reset must win.
        Reset = 1'b1;
        Start = 1'b1;
        A     = 8'h05;
        B     = 8'h05;
        repeat (3) @(negedge clk);
        check("rst_busy",    16'(Busy),      16'd0);
        check("rst_done",    16'(Done),      16'd0);
        check("rst_product", Product,        16'h0000);
        check("rst_state",   16'(dbg_state), 16'd0);
        Reset  = 1'b0;
        Start  = 1'b0;
        mon_en = 1'b1;

        // Directed table; the first entry is also the first Start after reset.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Start and operand changes during RUN must be ignored.
        run_op(8'h03, 8'h05, 16'h000F, 1'b1, "noise");

        // Reset in cycle N+4 aborts an FF*FF operation.
        @(negedge clk);
        Start = 1'b1;
        A     = 8'hFF;
        B     = 8'hFF;
        exp_q.push_back(16'hFE01);
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        check("abort_busy",    16'(Busy), 16'd0);
        check("abort_done",    16'(Done), 16'd0);
        check("abort_product", Product,   16'h0000);
        Reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_done", 16'(Done), 16'd0);
        end
        run_op(8'h02, 8'h03, 16'h0006, 1'b0, "after_abort");

        // Random back-to-back regression against plain multiplication.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, 16'(ra) * 16'(rb), 1'(i % 2), "rand");
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
